tentry_bcd2tc: RTL and testbench

//  Inverse of the temperature display path: accepts a sign plus four BCD digits
//  (thousands..ones) and produces the two's-complement temperature word tc.

---
 rtl/tdisplay_pkg.sv | 26 ++
 rtl/tentry_bcd2tc_bcd_mac10.sv | 19 +
 rtl/tentry_bcd2tc.sv | 147 ++++++++++++++
 tb/tb_tentry_bcd2tc.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/tdisplay_pkg.sv
// Shared temperature display/entry definitions: FSM states, digit count,
// accumulator width and two's-complement range helpers.
package tdisplay_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    FIN,
    DONE
  } state_t;

  localparam int BCD_DIGITS = 4;
  localparam int ACC_W      = 14;   // holds 0..9999 unsigned
  localparam int IDX_W      = 2;    // indexes BCD_DIGITS digits

  // Largest positive value representable in a tc_w-bit two's-complement word.
  function automatic int tc_max_pos(input int tc_w);
    return (1 << (tc_w - 1)) - 1;
  endfunction

  // Magnitude of the most negative tc_w-bit two's-complement value.
  function automatic int tc_max_neg_mag(input int tc_w);
    return 1 << (tc_w - 1);
  endfunction

endpackage

// File: rtl/tentry_bcd2tc_bcd_mac10.sv
// Combinational multiply-accumulate step: acc*10 + digit, with a flag for a
// digit that is not valid BCD. Result wraps at ACC_W bits; a wrapped value
// only occurs alongside a bad digit, which forces an error downstream.
module bcd_mac10
  import tdisplay_pkg::*;
(
  input  logic [ACC_W-1:0] acc_in,
  input  logic [3:0]       digit,
  output logic [ACC_W-1:0] acc_out,
  output logic             digit_bad
);

  // acc*10 built from two shifts so no multiplier is inferred.
  always_comb begin
    acc_out   = (acc_in << 3) + (acc_in << 1) + {{(ACC_W-4){1'b0}}, digit};
    digit_bad = (digit > 4'd9);
  end

endmodule

// File: rtl/tentry_bcd2tc.sv
// Sign + four BCD digits -> two's-complement temperature word.
// One digit folded in per cycle, then a range check and a registered result
// held until the downstream handshake.
// Optional build macro: BCD2TC_SAT_EN -- out-of-range magnitudes saturate
// instead of reporting err.
module tentry_bcd2tc
  import tdisplay_pkg::*;
#(
  parameter int TC_W = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      thousands,
  input  logic [3:0]      hundreds,
  input  logic [3:0]      tens,
  input  logic [3:0]      ones,
  input  logic            sign,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TC_W-1:0] tc,
  output logic            err
);

  localparam logic [31:0] POS_MAX = 32'(tc_max_pos(TC_W));
  localparam logic [31:0] NEG_MAG = 32'(tc_max_neg_mag(TC_W));

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               idx_q, idx_d;
  logic [BCD_DIGITS-1:0][3:0]     digits_q, digits_d;   // [0] = thousands
  logic                           sign_q, sign_d;
  logic [ACC_W-1:0]               acc_q, acc_d;
  logic                           bad_q, bad_d;
  logic [TC_W-1:0]                tc_q, tc_d;
  logic                           err_q, err_d;
  logic                           out_valid_q, out_valid_d;

  logic [ACC_W-1:0]               mac_out;
  logic                           mac_bad;
  logic [31:0]                    acc_ext;

  bcd_mac10 u_mac (
    .acc_in    (acc_q),
    .digit     (digits_q[idx_q]),
    .acc_out   (mac_out),
    .digit_bad (mac_bad)
  );

  assign acc_ext   = 32'(acc_q);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign tc        = tc_q;
  assign err       = err_q;

  // Next-state and datapath: capture, accumulate, range-check, hold result.
  always_comb begin
    // NOTE: every _d takes its _q value first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_d     = state_q;
    idx_d       = idx_q;
    digits_d    = digits_q;
    sign_d      = sign_q;
    acc_d       = acc_q;
    bad_d       = bad_q;
    tc_d        = tc_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          digits_d = {ones, tens, hundreds, thousands};
          sign_d   = sign;
          acc_d    = '0;
          bad_d    = 1'b0;
          idx_d    = '0;
          state_d  = ACC;
        end
      end

      ACC: begin
        acc_d = mac_out;
        bad_d = bad_q | mac_bad;
        idx_d = idx_q + 1'b1;
        if (idx_q == IDX_W'(BCD_DIGITS - 1)) state_d = FIN;
      end

      FIN: begin
        out_valid_d = 1'b1;
        state_d     = DONE;
        if (bad_q) begin
          tc_d  = '0;
          err_d = 1'b1;
        end else if (sign_q ? (acc_ext > NEG_MAG) : (acc_ext > POS_MAX)) begin
`ifdef BCD2TC_SAT_EN
          tc_d  = sign_q ? TC_W'(32'd0 - NEG_MAG) : TC_W'(POS_MAX);
          err_d = 1'b0;
`else
          tc_d  = '0;
          err_d = 1'b1;
`endif
        end else begin
          // Negating zero gives zero, so -0 needs no special case.
          tc_d  = sign_q ? TC_W'(32'd0 - acc_ext) : TC_W'(acc_ext);
          err_d = 1'b0;
        end
      end

      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any conversion in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      digits_q    <= '0;
      sign_q      <= 1'b0;
      acc_q       <= '0;
      bad_q       <= 1'b0;
      tc_q        <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q     <= state_d;
      idx_q       <= idx_d;
      digits_q    <= digits_d;
      sign_q      <= sign_d;
      acc_q       <= acc_d;
      bad_q       <= bad_d;
      tc_q        <= tc_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_tentry_bcd2tc.sv
// Bench for tentry_bcd2tc: directed vectors, an arithmetic reference model,
// a per-cycle output compare process and literal pins on the model.
module tb_tentry_bcd2tc;

  localparam int TC_W = 13;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [3:0]      thousands = '0, hundreds = '0, tens = '0, ones = '0;
  logic            sign = 1'b0;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [TC_W-1:0] tc;
  logic            err;

  int total = 0;
  int bad   = 0;

  logic            chk_en = 1'b0;
  logic [TC_W-1:0] exp_tc = '0;
  logic            exp_err = 1'b0;

  tentry_bcd2tc #(.TC_W(TC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .thousands (thousands),
    .hundreds  (hundreds),
    .tens      (tens),
    .ones      (ones),
    .sign      (sign),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .tc        (tc),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: decimal value from the digits, then signed range rules.
  function automatic logic [TC_W:0] model(input logic s, input logic [3:0] d3, d2, d1, d0);
    int mag;
    int val;
    int lim;
    if (d3 > 9 || d2 > 9 || d1 > 9 || d0 > 9) return {1'b1, {TC_W{1'b0}}};
    mag = d3 * 1000 + d2 * 100 + d1 * 10 + d0;
    lim = s ? (1 << (TC_W - 1)) : (1 << (TC_W - 1)) - 1;
    if (mag > lim) begin
`ifdef BCD2TC_SAT_EN
      val = s ? -(1 << (TC_W - 1)) : lim;
      return {1'b0, TC_W'(val)};
`else
      return {1'b1, {TC_W{1'b0}}};
`endif
    end
    val = s ? -mag : mag;
    return {1'b0, TC_W'(val)};
  endfunction

  // Whenever a result is presented it must match the model and the block must be busy.
  always @(negedge clk) begin
    if (rst_n && chk_en && out_valid) begin
      check("out_tc", 32'(tc), 32'(exp_tc));
      check("out_err", 32'(err), 32'(exp_err));
      check("ready_while_valid", 32'(in_ready), 32'd0);
    end
  end

  // Submit one value, verify latency and busy behaviour, hold, then release.
  task automatic convert(input logic s, input logic [3:0] d3, d2, d1, d0, input int hold,
                         input logic use_lit, input logic [TC_W-1:0] lit_tc, input logic lit_err);
    logic [TC_W:0] m;
    int c;
    m = model(s, d3, d2, d1, d0);
    if (use_lit) begin
      check("model_tc_pin", 32'(m[TC_W-1:0]), 32'(lit_tc));
      check("model_err_pin", 32'(m[TC_W]), 32'(lit_err));
    end
    c = 0;
    while (!in_ready && c < 20) begin @(negedge clk); c++; end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    exp_tc = m[TC_W-1:0]; exp_err = m[TC_W]; chk_en = 1'b1;
    sign = s; thousands = d3; hundreds = d2; tens = d1; ones = d0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    sign = ~s; thousands = 4'h9; hundreds = 4'h9; tens = 4'h9; ones = 4'h9;
    c = 0;
    while (!out_valid && c < 20) begin
      check("busy_in_ready", 32'(in_ready), 32'd0);
      in_valid = (c == 1);
      @(negedge clk);
      c++;
    end
    in_valid = 1'b0;
    check("latency", 32'(c), 32'd5);
    if (use_lit) begin
      check("lit_tc", 32'(tc), 32'(lit_tc));
      check("lit_err", 32'(err), 32'(lit_err));
    end
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      @(negedge clk);
      check("hold_valid", 32'(out_valid), 32'd1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_valid", 32'(out_valid), 32'd0);
    check("release_ready", 32'(in_ready), 32'd1);
    chk_en = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_tc"}, 32'(tc), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_values("post_reset");

    convert(1'b1, 4'd0, 4'd0, 4'd0, 4'd5, 0, 1'b1, 13'h1FFB, 1'b0);
    convert(1'b0, 4'd4, 4'd0, 4'd9, 4'd5, 0, 1'b1, 13'h0FFF, 1'b0);
    convert(1'b1, 4'd4, 4'd0, 4'd9, 4'd6, 0, 1'b1, 13'h1000, 1'b0);
`ifdef BCD2TC_SAT_EN
    convert(1'b0, 4'd4, 4'd0, 4'd9, 4'd6, 0, 1'b1, 13'h0FFF, 1'b0);
    convert(1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 1, 1'b1, 13'h1000, 1'b0);
`else
    convert(1'b0, 4'd4, 4'd0, 4'd9, 4'd6, 0, 1'b1, 13'h0000, 1'b1);
    convert(1'b1, 4'd9, 4'd9, 4'd9, 4'd9, 1, 1'b1, 13'h0000, 1'b1);
`endif
    convert(1'b0, 4'd1, 4'hA, 4'd0, 4'd0, 0, 1'b1, 13'h0000, 1'b1);
    convert(1'b1, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b1, 13'h0000, 1'b0);
    convert(1'b0, 4'd1, 4'd2, 4'd3, 4'd4, 10, 1'b1, 13'h04D2, 1'b0);
    convert(1'b1, 4'd4, 4'd0, 4'd9, 4'd7, 2, 1'b0, '0, 1'b0);
    convert(1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 0, 1'b0, '0, 1'b0);
    convert(1'b1, 4'd0, 4'hF, 4'd0, 4'd0, 0, 1'b0, '0, 1'b0);
    convert(1'b0, 4'd9, 4'd9, 4'd9, 4'd9, 3, 1'b0, '0, 1'b0);

    // Abort during the third accumulate cycle.
    sign = 1'b0; thousands = 4'd3; hundreds = 4'd3; tens = 4'd3; ones = 4'd3;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk);
    check_reset_values("abort_hold");
    rst_n = 1'b1;
    @(negedge clk);
    convert(1'b1, 4'd2, 4'd0, 4'd4, 4'd8, 1, 1'b1, 13'h1800, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
